// File: rtl/perf_counter_bank_if.sv
// perf_counter_bank_if: bundles the event, control, configuration and read-port
// signals of perf_counter_bank. Clock and reset stay outside as plain ports.
//
// Signals:
//   evt_i      level event lines, synchronous to the bank clock
//   start_i    enter RUN
//   stop_i     enter IDLE
//   clear_i    zero live counters and overflow flags
//   snap_i     copy live counters into shadow registers
//   cfg_we_i   configuration write strobe
//   cfg_idx_i  counter being configured
//   cfg_evt_i  event select for the configured counter
//   cfg_mode_i count mode: 00 OFF, 01 LEVEL, 10 EDGE, 11 CYCLES
//   rd_idx_i   shadow register to read
//   rd_data_o  registered shadow read data
//   ovf_o      sticky per-counter overflow flags
//   running_o  high while in RUN
// Modports: slave = the counter bank, master = whoever drives it.
interface perf_counter_bank_if #(
  parameter int unsigned NUM_CNT   = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned NUM_EVT   = 8
);
  localparam int unsigned IdxW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
  localparam int unsigned EvtW = $clog2(NUM_EVT);

  logic [NUM_EVT-1:0]   evt_i;
  logic                 start_i;
  logic                 stop_i;
  logic                 clear_i;
  logic                 snap_i;
  logic                 cfg_we_i;
  logic [IdxW-1:0]      cfg_idx_i;
  logic [EvtW-1:0]      cfg_evt_i;
  logic [1:0]           cfg_mode_i;
  logic [IdxW-1:0]      rd_idx_i;
  logic [CNT_WIDTH-1:0] rd_data_o;
  logic [NUM_CNT-1:0]   ovf_o;
  logic                 running_o;

  modport slave (
    input  evt_i, start_i, stop_i, clear_i, snap_i,
    input  cfg_we_i, cfg_idx_i, cfg_evt_i, cfg_mode_i, rd_idx_i,
    output rd_data_o, ovf_o, running_o
  );

  modport master (
    output evt_i, start_i, stop_i, clear_i, snap_i,
    output cfg_we_i, cfg_idx_i, cfg_evt_i, cfg_mode_i, rd_idx_i,
    input  rd_data_o, ovf_o, running_o
  );
endinterface

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CNT independent performance counters for the RV32I
// pipeline. Each counter selects one event line and a count mode (OFF, LEVEL,
// EDGE, CYCLES). A global IDLE/RUN FSM gates counting; clear zeroes live
// counters and overflow flags; snap copies live counters into shadow registers,
// which are read back through a registered read port.
//
// Ports:
//   clk_i   single clock, rising edge
//   rstn_i  asynchronous active-low reset
//   bus_io  perf_counter_bank_if slave modport (events, strobes, config, read)
module perf_counter_bank #(
  parameter int unsigned NUM_CNT   = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned NUM_EVT   = 8,
  parameter bit          SATURATE  = 1'b0
) (
  input logic                 clk_i,
  input logic                 rstn_i,
  perf_counter_bank_if.slave  bus_io
);

  localparam int unsigned IdxW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
  localparam int unsigned EvtW = $clog2(NUM_EVT);
  // One extra bit so NUM_EVT itself is representable for the range check.
  localparam logic [EvtW:0] NumEvtL = (EvtW + 1)'(NUM_EVT);

  typedef enum logic {StIdle, StRun} state_e;
  typedef enum logic [1:0] {ModeOff, ModeLevel, ModeEdge, ModeCycles} mode_e;

  state_e               r_state;
  logic                 r_running;
  logic [NUM_EVT-1:0]   r_evt_q;
  logic [CNT_WIDTH-1:0] r_cnt     [NUM_CNT];
  logic [CNT_WIDTH-1:0] r_shadow  [NUM_CNT];
  logic [EvtW-1:0]      r_cfg_evt [NUM_CNT];
  mode_e                r_cfg_mode[NUM_CNT];
  logic [NUM_CNT-1:0]   r_ovf;
  logic [CNT_WIDTH-1:0] r_rd_data;

  logic [NUM_CNT-1:0]   w_hit;
  logic [NUM_CNT-1:0]   w_inc;
  logic                 w_cfg_ok;
  logic [CNT_WIDTH-1:0] w_rd_data;

  // ---------------------------------------------------------------------------
  // Run-control FSM. Clear never moves the FSM; stop still acts when it
  // arrives together with clear, and stop beats start.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= StIdle;
      r_running <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus_io.start_i && !bus_io.stop_i) begin
            r_state   <= StRun;
            r_running <= 1'b1;
          end
        end
        StRun: begin
          if (bus_io.stop_i) begin
            r_state   <= StIdle;
            r_running <= 1'b0;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-counter count condition, using the configuration in effect this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      unique case (r_cfg_mode[i])
        ModeOff:    w_hit[i] = 1'b0;
        ModeLevel:  w_hit[i] = bus_io.evt_i[r_cfg_evt[i]];
        ModeEdge:   w_hit[i] = bus_io.evt_i[r_cfg_evt[i]] & ~r_evt_q[r_cfg_evt[i]];
        ModeCycles: w_hit[i] = 1'b1;
      endcase
    end
  end

  assign w_inc = w_hit & {NUM_CNT{r_state == StRun}};

  // Out-of-range counter indices simply match no entry below; out-of-range
  // event selects must reject the whole write.
  assign w_cfg_ok = bus_io.cfg_we_i && ({1'b0, bus_io.cfg_evt_i} < NumEvtL);

  // ---------------------------------------------------------------------------
  // Event history, configuration, live counters, overflow flags and shadows.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_evt_q <= '0;
      r_ovf   <= '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        r_cnt[i]      <= '0;
        r_shadow[i]   <= '0;
        r_cfg_evt[i]  <= '0;
        r_cfg_mode[i] <= ModeOff;
      end
    end else begin
      r_evt_q <= bus_io.evt_i;
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_cfg_ok && (bus_io.cfg_idx_i == IdxW'(i))) begin
          r_cfg_evt[i]  <= bus_io.cfg_evt_i;
          r_cfg_mode[i] <= mode_e'(bus_io.cfg_mode_i);
        end

        // Snapshot takes the pre-edge value, so it ignores this cycle's
        // increment or clear.
        if (bus_io.snap_i) begin
          r_shadow[i] <= r_cnt[i];
        end

        if (bus_io.clear_i) begin
          r_cnt[i] <= '0;
          r_ovf[i] <= 1'b0;
        end else if (w_inc[i]) begin
          if (&r_cnt[i]) begin
            r_ovf[i] <= 1'b1;
            r_cnt[i] <= SATURATE ? r_cnt[i] : '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port; an index with no matching counter reads as zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (bus_io.rd_idx_i == IdxW'(i)) begin
        w_rd_data = r_shadow[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_data;
    end
  end

  assign bus_io.rd_data_o = r_rd_data;
  assign bus_io.ovf_o     = r_ovf;
  assign bus_io.running_o = r_running;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed testbench for perf_counter_bank. Two instances share stimulus: one
// wraps on overflow, one saturates. 8-bit counters keep the overflow test short;
// six event lines make an out-of-range event select expressible.
module tb_perf_counter_bank;

  localparam int unsigned NCnt = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned NEvt = 6;

  localparam logic [1:0] MOff    = 2'd0;
  localparam logic [1:0] MLevel  = 2'd1;
  localparam logic [1:0] MEdge   = 2'd2;
  localparam logic [1:0] MCycles = 2'd3;

  logic clk = 1'b0;
  logic rstn;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  perf_counter_bank_if #(.NUM_CNT(NCnt), .CNT_WIDTH(CW), .NUM_EVT(NEvt)) u_if0 ();
  perf_counter_bank_if #(.NUM_CNT(NCnt), .CNT_WIDTH(CW), .NUM_EVT(NEvt)) u_if1 ();

  assign u_if1.evt_i      = u_if0.evt_i;
  assign u_if1.start_i    = u_if0.start_i;
  assign u_if1.stop_i     = u_if0.stop_i;
  assign u_if1.clear_i    = u_if0.clear_i;
  assign u_if1.snap_i     = u_if0.snap_i;
  assign u_if1.cfg_we_i   = u_if0.cfg_we_i;
  assign u_if1.cfg_idx_i  = u_if0.cfg_idx_i;
  assign u_if1.cfg_evt_i  = u_if0.cfg_evt_i;
  assign u_if1.cfg_mode_i = u_if0.cfg_mode_i;
  assign u_if1.rd_idx_i   = u_if0.rd_idx_i;

  perf_counter_bank #(
    .NUM_CNT(NCnt), .CNT_WIDTH(CW), .NUM_EVT(NEvt), .SATURATE(1'b0)
  ) u_dut0 (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus_io (u_if0.slave)
  );

  perf_counter_bank #(
    .NUM_CNT(NCnt), .CNT_WIDTH(CW), .NUM_EVT(NEvt), .SATURATE(1'b1)
  ) u_dut1 (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus_io (u_if1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic strobe(input bit st, input bit sp, input bit cl, input bit sn);
    u_if0.start_i = st;
    u_if0.stop_i  = sp;
    u_if0.clear_i = cl;
    u_if0.snap_i  = sn;
    tick();
    u_if0.start_i = 1'b0;
    u_if0.stop_i  = 1'b0;
    u_if0.clear_i = 1'b0;
    u_if0.snap_i  = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [2:0] evt, input logic [1:0] mode);
    u_if0.cfg_we_i   = 1'b1;
    u_if0.cfg_idx_i  = idx;
    u_if0.cfg_evt_i  = evt;
    u_if0.cfg_mode_i = mode;
    tick();
    u_if0.cfg_we_i   = 1'b0;
  endtask

  task automatic read_shadow(input logic [1:0] idx, output logic [CW-1:0] d0,
                             output logic [CW-1:0] d1);
    u_if0.rd_idx_i = idx;
    tick();
    d0 = u_if0.rd_data_o;
    d1 = u_if1.rd_data_o;
  endtask

  initial begin
    logic [CW-1:0] d0, d1;
    logic [0:8]    pat;

    rstn             = 1'b0;
    u_if0.evt_i      = '0;
    u_if0.start_i    = 1'b0;
    u_if0.stop_i     = 1'b0;
    u_if0.clear_i    = 1'b0;
    u_if0.snap_i     = 1'b0;
    u_if0.cfg_we_i   = 1'b0;
    u_if0.cfg_idx_i  = '0;
    u_if0.cfg_evt_i  = '0;
    u_if0.cfg_mode_i = '0;
    u_if0.rd_idx_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Reset state
    check("rst_rd_data", 32'(u_if0.rd_data_o), 0);
    check("rst_ovf",     32'(u_if0.ovf_o),     0);
    check("rst_running", 32'(u_if0.running_o), 0);

    // Cycle count: 10 idle-wait cycles plus the stop cycle
    cfg_write(2'd0, 3'd0, MCycles);
    strobe(1, 0, 0, 0);
    check("start_running", 32'(u_if0.running_o), 1);
    repeat (10) tick();
    strobe(0, 1, 0, 0);
    check("stop_running", 32'(u_if0.running_o), 0);
    strobe(0, 0, 0, 1);
    read_shadow(2'd0, d0, d1);
    check("cycle_cnt", 32'(d0), 11);

    // Edge vs level on event 2
    strobe(0, 0, 1, 0);
    cfg_write(2'd1, 3'd2, MEdge);
    cfg_write(2'd2, 3'd2, MLevel);
    strobe(1, 0, 0, 0);
    pat = 9'b110100111;
    for (int i = 0; i < 9; i++) begin
      u_if0.evt_i = 6'(pat[i]) << 2;
      tick();
    end
    u_if0.evt_i = '0;
    strobe(0, 1, 0, 0);
    strobe(0, 0, 0, 1);
    read_shadow(2'd1, d0, d1);
    check("edge_cnt", 32'(d0), 3);
    read_shadow(2'd2, d0, d1);
    check("level_cnt", 32'(d0), 6);
    read_shadow(2'd0, d0, d1);
    check("cycles_during_pattern", 32'(d0), 10);
    read_shadow(2'd3, d0, d1);
    check("off_cnt", 32'(d0), 0);

    // Wrap vs saturate over 257 counted cycles
    strobe(0, 0, 1, 0);
    strobe(1, 0, 0, 0);
    repeat (256) tick();
    strobe(0, 1, 0, 0);
    check("wrap_ovf", 32'(u_if0.ovf_o), 1);
    check("sat_ovf",  32'(u_if1.ovf_o), 1);
    strobe(0, 0, 0, 1);
    read_shadow(2'd0, d0, d1);
    check("wrap_cnt", 32'(d0), 1);
    check("sat_cnt",  32'(d1), 255);
    strobe(0, 0, 1, 0);
    check("wrap_ovf_clr", 32'(u_if0.ovf_o), 0);
    check("sat_ovf_clr",  32'(u_if1.ovf_o), 0);
    strobe(0, 0, 0, 1);
    read_shadow(2'd0, d0, d1);
    check("wrap_cnt_clr", 32'(d0), 0);
    check("sat_cnt_clr",  32'(d1), 0);

    // Snapshot + clear + stop in one cycle, counter 0 at 5
    strobe(1, 0, 0, 0);
    repeat (5) tick();
    strobe(0, 1, 1, 1);
    check("simul_running", 32'(u_if0.running_o), 0);
    tick();
    read_shadow(2'd0, d0, d1);
    check("simul_shadow", 32'(d0), 5);
    strobe(0, 0, 0, 1);
    read_shadow(2'd0, d0, d1);
    check("simul_live", 32'(d0), 0);

    // Configuration timing: counter 3 OFF -> CYCLES at cycle c
    strobe(0, 0, 1, 0);
    strobe(1, 0, 0, 0);
    u_if0.cfg_we_i   = 1'b1;
    u_if0.cfg_idx_i  = 2'd3;
    u_if0.cfg_evt_i  = 3'd0;
    u_if0.cfg_mode_i = MCycles;
    tick();                       // cycle c
    u_if0.cfg_we_i   = 1'b0;
    u_if0.snap_i     = 1'b1;
    tick();                       // c+1: shadow3 <- value after c
    u_if0.rd_idx_i   = 2'd3;
    tick();                       // c+2: read shadow3, snap value after c+1
    u_if0.snap_i     = 1'b0;
    check("cfg_after_c", 32'(u_if0.rd_data_o), 0);
    tick();
    check("cfg_after_c1", 32'(u_if0.rd_data_o), 1);

    // Out-of-range event select: write must not touch counter 2 (LEVEL, evt 2)
    strobe(0, 0, 1, 0);
    cfg_write(2'd2, 3'd7, MOff);
    u_if0.evt_i = 6'b000100;
    repeat (3) tick();
    u_if0.evt_i = '0;
    strobe(0, 0, 0, 1);
    read_shadow(2'd2, d0, d1);
    check("cfg_oor_ignored", 32'(d0), 3);

    // Asynchronous reset while counting at 40
    strobe(0, 0, 1, 0);
    repeat (40) tick();
    check("pre_rst_running", 32'(u_if0.running_o), 1);
    check("pre_rst_rd_data", 32'(u_if0.rd_data_o), 3);
    #3;
    rstn = 1'b0;
    #1;
    check("async_rst_rd_data", 32'(u_if0.rd_data_o), 0);
    check("async_rst_running", 32'(u_if0.running_o), 0);
    check("async_rst_ovf",     32'(u_if0.ovf_o),     0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    read_shadow(2'd0, d0, d1);
    check("post_rst_shadow0", 32'(d0), 0);
    strobe(1, 0, 0, 0);
    check("post_rst_running", 32'(u_if0.running_o), 1);
    u_if0.evt_i = '1;
    repeat (5) tick();
    u_if0.evt_i = '0;
    strobe(0, 1, 0, 0);
    strobe(0, 0, 0, 1);
    for (int i = 0; i < NCnt; i++) begin
      read_shadow(2'(i), d0, d1);
      check($sformatf("post_rst_cfg_off%0d", i), 32'(d0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
